// File: rtl/regfile_pkg.sv
// Shared sizing and types for the architectural integer register file.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef logic [63:0]       word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/decoder5_32.sv
// Enable-gated 5:32 one-hot decoder; the zero-register slot never asserts.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic                en,
  input  reg_idx_t            idx,
  output logic [NUM_REGS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    // Gating on en first keeps an X index from reaching any enable while idle.
    if (en) onehot[idx] = 1'b1;
    onehot[ZERO_REG] = 1'b0;
  end
endmodule

// File: rtl/mux32_1_64.sv
// 64-bit 32:1 read multiplexer.
module mux32_1_64
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0][63:0] din,
  input  reg_idx_t                  sel,
  output word_t                     dout
);
  assign dout = din[sel];
endmodule

// File: rtl/reg64_en.sv
// 64-bit register with synchronous active-high clear and write enable.
module reg64_en
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  writeEnable,
  input  word_t writeData,
  output word_t dataOut
);
  always_ff @(posedge clk) begin
    if (reset)            dataOut <= '0;
    else if (writeEnable) dataOut <= writeData;
  end
endmodule

// File: rtl/reg_file_32x64.sv
// 32x64 register file: two combinational read ports, one write port, same-cycle bypass.
module reg_file_32x64 #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regWrite,
  input  logic [4:0]       writeReg,
  input  logic [WIDTH-1:0] writeData,
  input  logic [4:0]       readReg1,
  input  logic [4:0]       readReg2,
  output logic [WIDTH-1:0] readData1,
  output logic [WIDTH-1:0] readData2
);
  import regfile_pkg::NUM_REGS;
  import regfile_pkg::word_t;

  logic [NUM_REGS-1:0]            wrEn;
  logic [NUM_REGS-1:0][WIDTH-1:0] regQ;
  word_t                          mux1, mux2;
  logic                           hit1, hit2;

  decoder5_32 uDec (
    .en     (regWrite),
    .idx    (writeReg),
    .onehot (wrEn)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
    if (i == ZERO_REG) begin : gZero
      assign regQ[i] = '0;
    end else begin : gStore
      reg64_en uReg (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (wrEn[i]),
        .writeData   (writeData),
        .dataOut     (regQ[i])
      );
    end
  end

  mux32_1_64 uMux1 (.din(regQ), .sel(readReg1), .dout(mux1));
  mux32_1_64 uMux2 (.din(regQ), .sel(readReg2), .dout(mux2));

  // The one-hot enable already folds in regWrite, the index match and the
  // zero-register exclusion, so selecting it by the read index is the compare.
  assign hit1 = wrEn[readReg1];
  assign hit2 = wrEn[readReg2];

  assign readData1 = hit1 ? writeData : mux1;
  assign readData2 = hit2 ? writeData : mux2;
endmodule

// File: tb/tb_reg_file_32x64.sv
// Scoreboard bench for reg_file_32x64: expected reads are queued as driven, popped when sampled.
module tb_reg_file_32x64;
  typedef logic [63:0] word_t;
  typedef struct {
    string tag;
    bit    port;
    word_t exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset, regWrite;
  logic [4:0]  writeReg, readReg1, readReg2;
  word_t       writeData, readData1, readData2;

  word_t model [0:30];
  sb_t   sbq [$];
  int    nChecks = 0;
  int    nFails  = 0;

  reg_file_32x64 dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic word_t expRead(input logic [4:0] idx);
    if (idx == 5'd31) return '0;
    if (regWrite === 1'b1 && writeReg === idx) return writeData;
    return model[idx];
  endfunction

  // Clock edge: advance the model the way the architecture defines a write/reset.
  task automatic tick();
    @(posedge clk);
    if (reset === 1'b1) begin
      for (int i = 0; i < 31; i++) model[i] = '0;
    end else if (regWrite === 1'b1 && writeReg !== 5'd31) begin
      model[writeReg] = writeData;
    end
    #1;
  endtask

  task automatic rdExp(input logic [4:0] a, input logic [4:0] b,
                       input word_t e1, input word_t e2, input string tag);
    sb_t s;
    readReg1 = a;
    readReg2 = b;
    sbq.push_back('{tag: $sformatf("%s_p1_r%0d", tag, a), port: 1'b0, exp: e1});
    sbq.push_back('{tag: $sformatf("%s_p2_r%0d", tag, b), port: 1'b1, exp: e2});
    #1;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      chk(s.tag, s.port ? readData2 : readData1, s.exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b, input string tag);
    rdExp(a, b, expRead(a), expRead(b), tag);
  endtask

  task automatic readAll(input string tag);
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), tag);
  endtask

  task automatic wr(input logic [4:0] idx, input word_t d);
    regWrite  = 1'b1;
    writeReg  = idx;
    writeData = d;
    tick();
    regWrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;
    for (int i = 0; i < 31; i++) model[i] = 'x;
    #1;
    rdExp(5'd31, 5'd31, 64'h0, 64'h0, "zero_pre_reset");
    tick();
    reset = 1'b0;
    readAll("reset_state");

    for (int i = 0; i < 32; i++) wr(5'(i), 64'h0102040800000000 | 64'(i));
    readAll("wr_readback");
    rdExp(5'd30, 5'd31, 64'h010204080000001E, 64'h0, "wr_const");

    reset = 1'b1; tick(); reset = 1'b0;
    readAll("reset_after_fill");

    for (int i = 0; i < 31; i++) wr(5'(i), 64'hC0DE_0000_0000_0000 | 64'(i * 3 + 1));
    regWrite = 1'b1; writeReg = 5'd31; writeData = '1;
    rdExp(5'd31, 5'd31, 64'h0, 64'h0, "zero_wr_same");
    tick();
    regWrite = 1'b0;
    rdExp(5'd31, 5'd31, 64'h0, 64'h0, "zero_wr_next");
    readAll("zero_wr_others");

    wr(5'd5, 64'hA0);
    regWrite = 1'b1; writeReg = 5'd5; writeData = 64'hDEADBEEF;
    rdExp(5'd5, 5'd5, 64'hDEADBEEF, 64'hDEADBEEF, "bypass_both");
    rdExp(5'd5, 5'd6, 64'hDEADBEEF, expRead(5'd6), "bypass_p1only");
    tick();
    regWrite = 1'b0;
    rdExp(5'd5, 5'd5, 64'hDEADBEEF, 64'hDEADBEEF, "bypass_stored");

    wr(5'd7, 64'h55);
    regWrite = 1'b0; writeReg = 5'd7; writeData = 64'h1234;
    rdExp(5'd7, 5'd7, 64'h55, 64'h55, "wr_dis_same");
    tick();
    rdExp(5'd7, 5'd7, 64'h55, 64'h55, "wr_dis_next");

    writeReg = 'x;
    tick();
    readAll("x_idx_idle");

    regWrite = 1'b1; writeReg = 5'd12; writeData = 64'h7777;
    rdExp(5'd3, 5'd12, expRead(5'd3), 64'h7777, "bypass_p2only");
    tick();
    regWrite = 1'b0;
    rd(5'd12, 5'd3, "p2_stored");

    reset = 1'b1; regWrite = 1'b1; writeReg = 5'd3; writeData = 64'h99;
    rdExp(5'd3, 5'd3, 64'h99, 64'h99, "collide_bypass");
    tick();
    reset = 1'b0; regWrite = 1'b0;
    rdExp(5'd3, 5'd3, 64'h0, 64'h0, "collide_after");
    readAll("collide_all");

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
